// File: rtl/systolic_instr_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : systolic_instr_sequencer
// Brief   : Decodes one instruction and runs clear/feed/flush/drain on the array.
// Revision: 1.0
// ----------------------------------------------------------------------------
module systolic_instr_sequencer #(
  parameter int N     = 32,
  parameter int LEN_W = 16,
  parameter int FLUSH = 2*N-2,
  localparam int ROW_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock_sink,
  input  logic             reset_sink_reset,
  input  logic [31:0]      st_instr_data,
  input  logic             st_instr_valid,
  output logic             st_instr_ready,
  input  logic             rows_valid,
  output logic             rows_ready,
  input  logic             cols_valid,
  output logic             cols_ready,
  output logic             feed_fire,
  output logic             array_step,
  output logic             acc_clear,
  output logic             drain_valid,
  input  logic             drain_ready,
  output logic [ROW_W-1:0] drain_row,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] instr_count,
  output logic             err_opcode
);

  localparam int FL_W = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_ACCUM  = 8'h01;
  localparam logic [7:0] OP_MATMUL = 8'h02;
  localparam logic [7:0] OP_DRAIN  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [FL_W-1:0]  flush_q, flush_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [7:0]       w_opcode;
  logic [LEN_W-1:0] w_len;
  logic             w_join;
  logic             w_unused;

  assign w_opcode = st_instr_data[23:16];
  assign w_len    = st_instr_data[LEN_W-1:0];
  assign w_join   = rows_valid & cols_valid;
  assign w_unused = ^st_instr_data[31:24];

  assign drain_row   = row_q;
  assign instr_count = cnt_q;
  assign err_opcode  = err_q;

  always_ff @(posedge clock_sink) begin
    if (reset_sink_reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    beat_d         = beat_q;
    flush_d        = flush_q;
    row_d          = row_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    st_instr_ready = (state_q == S_IDLE);
    busy           = (state_q != S_IDLE);
    rows_ready     = 1'b0;
    cols_ready     = 1'b0;
    feed_fire      = 1'b0;
    array_step     = 1'b0;
    acc_clear      = 1'b0;
    drain_valid    = 1'b0;
    done           = 1'b0;

    case (state_q)
      S_IDLE: begin
        beat_d  = '0;
        flush_d = '0;
        row_d   = '0;
        if (st_instr_valid) begin
          len_d = w_len;
          case (w_opcode)
            OP_MATMUL: state_d = (w_len == '0) ? S_DONE : S_CLEAR;
            OP_ACCUM:  state_d = (w_len == '0) ? S_DONE : S_FEED;
            OP_DRAIN:  state_d = S_DRAIN;
            OP_NOP:    state_d = S_DONE;
            default:   err_d   = 1'b1;
          endcase
        end
      end

      S_CLEAR: begin
        acc_clear = 1'b1;
        state_d   = S_FEED;
      end

      // Rows and columns advance together so the array always sees matched beats.
      S_FEED: begin
        rows_ready = w_join;
        cols_ready = w_join;
        feed_fire  = w_join;
        array_step = w_join;
        if (w_join) begin
          beat_d = beat_q + LEN_W'(1);
          if (beat_q == len_q - LEN_W'(1)) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        array_step = 1'b1;
        flush_d    = flush_q + FL_W'(1);
        if (flush_q == FL_W'(FLUSH - 1)) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        drain_valid = 1'b1;
        if (drain_ready) begin
          row_d = row_q + ROW_W'(1);
          if (row_q == ROW_W'(N - 1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        cnt_d   = cnt_q + LEN_W'(1);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/systolic_instr_sequencer.md
# systolic_instr_sequencer

Control sequencer for the 32x32 int8 systolic array. It accepts 32-bit instructions from the Avalon-ST instruction sink and decodes opcode and beat count. It then sequences one operation: accumulator clear, joined row/column operand feed, skew flush, and row-by-row result drain. It sits between `st_instr`, the `st_rows`/`st_cols` stream sinks and the PE array's control inputs inside `systolic_array_top`.

## Interface
- `N`, 32, array dimension; drain row count and skew depth
- `LEN_W`, 16, beat-count width; equals instruction field [15:0]
- `FLUSH`, 2*N-2, zero-input step cycles after the last feed beat
- `clock_sink` in 1: sole clock
- `reset_sink_reset` in 1: synchronous, active-high reset
- `st_instr_data` in 32: [31:24] reserved (ignored), [23:16] opcode, [15:0] beat count L
- `st_instr_valid` in 1 / `st_instr_ready` out 1: instruction handshake
- `rows_valid` in 1 / `rows_ready` out 1: row-stream handshake, gated by the sequencer
- `cols_valid` in 1 / `cols_ready` out 1: column-stream handshake, gated by the sequencer
- `feed_fire` out 1: array latches one row/column beat this cycle
- `array_step` out 1: array advances one cycle (feed or flush)
- `acc_clear` out 1: one-cycle pulse that zeroes all PE accumulators
- `drain_valid` out 1 / `drain_ready` in 1: result-row handshake toward `data_out`
- `drain_row` out 5 (log2 N): index of the row presented for drain
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle pulse when an instruction completes
- `instr_count` out LEN_W: completed instructions, wraps at 2^LEN_W
- `err_opcode` out 1: sticky illegal-opcode flag

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- IDLE: `st_instr_ready`=1 in IDLE only. On valid&ready, register opcode and L, then branch:
  - 0x02 MATMUL: to CLEAR.
  - 0x01 ACCUM: to FEED, skipping CLEAR.
  - 0x03 DRAIN: to DRAIN.
  - 0x00 NOP: to DONE.
  - Any other opcode: set `err_opcode` and return to IDLE. No `done`; `instr_count` unchanged.
- MATMUL/ACCUM with L=0: go directly to DONE. No clear, feed, flush or drain.
- CLEAR: `acc_clear`=1 for one cycle, then FEED.
- FEED:
  - Join: `rows_ready` = `cols_ready` = `feed_fire` = `array_step` = rows_valid & cols_valid.
  - Neither stream is consumed alone.
  - Beat counter counts fires. On fire number L, go to FLUSH.
- FLUSH: `array_step`=1, `feed_fire`=0 for exactly FLUSH cycles, then DRAIN.
- DRAIN:
  - `drain_valid`=1; `drain_row` starts at 0.
  - On drain_valid & drain_ready, increment `drain_row`.
  - After the accept with `drain_row`=N-1, go to DONE.
  - `drain_row` holds while `drain_ready`=0.
- DONE: `done`=1, `instr_count`+1 (wrapping), then IDLE.
- Outside FEED, `rows_ready` and `cols_ready` are 0. Upstream data is never dropped.
- `err_opcode` clears only on reset.

## Timing
- Reset (synchronous) forces:
  - State: IDLE.
  - Outputs at 0: `rows_ready`, `cols_ready`, `feed_fire`, `array_step`, `acc_clear`, `drain_valid`, `drain_row`, `busy`, `done`, `instr_count`, `err_opcode`.
  - `st_instr_ready`=1 from the first cycle after reset.
- Reset asserted in any state aborts the instruction in that cycle. Partial counts are discarded; no `done` is issued.
- Accept at cycle T, with continuous valid/ready:
  - MATMUL: CLEAR at T+1; FEED T+2..T+1+L; FLUSH T+2+L..T+1+L+FLUSH; DRAIN N cycles; DONE next.
  - IDLE and `st_instr_ready` again one cycle after DONE.
- All outputs are registered state decodes or combinational from state plus input valids. No input-to-output path exists other than the FEED join and the drain handshake.
- An instruction presented while `busy`=1 stalls (`st_instr_ready`=0) until IDLE.

## Test plan
- Instr 0x00020020 with rows/cols/drain_ready held at 1, accepted at T:
  - `acc_clear` at T+1.
  - 32 `feed_fire` at T+2..T+33.
  - `array_step` continuous T+2..T+95.
  - `drain_valid` T+96..T+127 with `drain_row` 0..31.
  - `done` at T+128; `instr_count`=1; `st_instr_ready` at T+129.
- Same instr, `cols_valid` low on odd cycles, `rows_valid` always 1:
  - `rows_ready`=0 whenever `cols_valid`=0.
  - Exactly 32 fires, ending at T+65.
  - `done` at T+160.
- DRAIN 0x00030000 with `drain_ready` low for 3 cycles at `drain_row`=5:
  - `drain_row` holds 5 through the stall.
  - 32 accepts total; `done` at T+36.
- ACCUM 0x00010004: no `acc_clear` pulse; 4 fires at T+1..T+4; 62 flush cycles.
- Opcode 0x07, then 0x00020000:
  - After 0x07: `err_opcode`=1 and stays set; `instr_count` unchanged; IDLE at T+1.
  - The L=0 MATMUL pulses `done` one cycle after accept, with no `acc_clear`.
- `reset_sink_reset` asserted for one cycle during FEED beat 10:
  - Next cycle: IDLE, `instr_count`=0, `rows_ready`=0.
  - The next instruction runs a full 32 feed beats.
